mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences data-memory loads/stores for the MEM pipeline stage over a req/ack RAM bus.
//  Latches one request, drives bus with byte lanes, waits for ack (with timeout), aligns and extends
//  load data, and holds the pipeline via stallreq until the access resolves. Sits between MEM and data RAM.
// PARAMETERS
//  DATA_W   32  data width (fixed 32; 4 byte lanes)
//  ADDR_W   32  byte address width
//  TIMEOUT  15  max ACCESS cycles without bus_ack before error; 0 = wait forever
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-low reset
//  req_valid   in   1       MEM stage presents an access this cycle
//  req_we      in   1       1=store, 0=load
//  req_size    in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1       1=sign-extend load, 0=zero-extend
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   DATA_W  store data (right-justified)
//  stallreq    out  1       stall request to pipeline control
//  resp_valid  out  1       one-cycle completion pulse
//  resp_rdata  out  DATA_W  load result (0 for stores/errors)
//  resp_err    out  1       misaligned/illegal size/timeout, valid with resp_valid
//  bus_ce      out  1       bus request
//  bus_we      out  1       bus write
//  bus_sel     out  4       byte-lane enables, sel[3]=bits[31:24]
//  bus_addr    out  ADDR_W  word-aligned address (addr[1:0]=00)
//  bus_wdata   out  DATA_W  lane-replicated store data
//  bus_ack     in   1       bus completes access this cycle
//  bus_rdata   in   DATA_W  read data, valid with bus_ack
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counter=0, all registered outputs 0; bus_ce drops immediately.
//  States: IDLE, ACCESS, DONE (registered).
//  IDLE: req_valid=1 -> latch we/size/signed/addr/wdata. Aligned & legal -> ACCESS; else -> DONE, err=1, no bus cycle.
//   Alignment: half needs addr[0]=0; word needs addr[1:0]=00; size 11 always illegal.
//  ACCESS: bus_ce=1, bus_we/sel/addr/wdata held stable from latched request every cycle.
//   bus_ack=1 -> capture aligned load data, -> DONE err=0.
//   No ack: counter++; counter==TIMEOUT (TIMEOUT!=0) -> DONE err=1, rdata=0. Counter cleared on entry.
//  DONE: resp_valid=1 for exactly one cycle with resp_rdata/resp_err; -> IDLE. req_valid ignored here.
//  Outside DONE: resp_valid=0, resp_rdata=0, resp_err=0. Outside ACCESS: bus_ce=0, bus_sel=0.
//  stallreq (combinational) = (IDLE & req_valid) | ACCESS; 0 in DONE so pipeline advances.
//  bus_ack in IDLE/DONE ignored. Latency, ack on first ACCESS cycle: accept T, ACCESS T+1, resp_valid T+2.
//  Byte lanes, big-endian: byte off k -> sel=1000>>k, lane [31-8k:24-8k]; half off 0 -> 1100, off 2 -> 0011; word -> 1111.
//  Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
//  Load: extract selected lane, sign-/zero-extend to 32 per req_signed; stores return rdata=0.
// TESTING
//  Word load addr 0x100, ack on 1st ACCESS cycle, bus_rdata 0x11223344 -> sel 1111, resp_valid at T+2, rdata 0x11223344, stallreq T,T+1.
//  Byte load addr 0x103 signed, bus_rdata 0x000000F0 -> sel 0001, rdata 0xFFFFFFF0; unsigned -> 0x000000F0.
//  Half store addr 0x202 wdata 0xABCD -> bus_addr 0x200, sel 0011, bus_wdata 0xABCDABCD, bus_we=1, rdata 0.
//  Word load addr 0x101 -> no bus_ce ever, resp_valid at T+1 with err=1; size 11 same.
//  No ack, TIMEOUT=15 -> bus_ce held 15 cycles then resp_err=1, rdata 0, stallreq falls in DONE.
//  rst=0 mid-ACCESS -> bus_ce/stallreq/resp_valid 0 immediately; next req after release runs normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the MEM stage: latches one load/store, runs a
// req/ack bus cycle with byte lanes and timeout, then returns aligned/extended load data.
module mem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stallreq,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              bus_ce,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is accepted on any rising edge where req_valid=1 in IDLE;
  // the bus holds ce/we/sel/addr/wdata stable until the edge on which bus_ack=1.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                req_legal;
  logic [CNT_W-1:0]    cnt_inc;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [DATA_W-1:0]   ld_ext;
  logic [3:0]          sel_lanes;
  logic [DATA_W-1:0]   wdata_rep;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Lane selection and data steering from the latched request (big-endian lanes).
  always_comb begin
    req_legal = 1'b0;
    case (req_size)
      2'b00:   req_legal = 1'b1;
      2'b01:   req_legal = ~req_addr[0];
      2'b10:   req_legal = (req_addr[1:0] == 2'b00);
      default: req_legal = 1'b0;
    endcase

    sel_lanes = 4'b0000;
    wdata_rep = wdata_q;
    case (size_q)
      2'b00: begin
        sel_lanes = 4'b1000 >> addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        sel_lanes = addr_q[1] ? 4'b0011 : 4'b1100;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        sel_lanes = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase

    case (addr_q[1:0])
      2'b00:   ld_byte = bus_rdata[31:24];
      2'b01:   ld_byte = bus_rdata[23:16];
      2'b10:   ld_byte = bus_rdata[15:8];
      default: ld_byte = bus_rdata[7:0];
    endcase
    ld_half = addr_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];

    case (size_q)
      2'b00:   ld_ext = signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
      2'b01:   ld_ext = signed_q ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    cnt_inc  = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = '0;
          rdata_d  = '0;
          if (req_legal) begin
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ACCESS: begin
        if (bus_ack) begin
          rdata_d = we_q ? '0 : ld_ext;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
          // TIMEOUT=0 lets the counter wrap freely and never aborts.
          if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stallreq   = ((state_q == S_IDLE) && req_valid) || (state_q == S_ACCESS);
    resp_valid = (state_q == S_DONE);
    resp_rdata = (state_q == S_DONE) ? rdata_q : '0;
    resp_err   = (state_q == S_DONE) ? err_q : 1'b0;
    bus_ce     = (state_q == S_ACCESS);
    bus_we     = (state_q == S_ACCESS) ? we_q : 1'b0;
    bus_sel    = (state_q == S_ACCESS) ? sel_lanes : 4'b0000;
    bus_addr   = (state_q == S_ACCESS) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    bus_wdata  = (state_q == S_ACCESS) ? wdata_rep : '0;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: driver tasks issue requests, a bus responder acks,
// and monitors compare responses and bus cycles against expected queues.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stallreq;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_ce;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_after = -1;
  logic [31:0] rdata_cfg = '0;
  logic [32:0] exp_q[$];
  logic [68:0] bus_q[$];

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stallreq(stallreq), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .bus_ce(bus_ce), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bus responder: acks on the ack_after-th ACCESS cycle (0-based), never if negative.
  initial begin
    int acc_cyc;
    acc_cyc = 0;
    forever begin
      @(negedge clk);
      if (bus_ce) begin
        bus_ack   = (acc_cyc == ack_after);
        bus_rdata = rdata_cfg;
        acc_cyc++;
      end else begin
        bus_ack = 1'b0;
        acc_cyc = 0;
      end
    end
  end

  // Response monitor.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("resp_err", 64'(resp_err), 64'(e[32]));
          chk("resp_rdata", 64'(resp_rdata), 64'(e[31:0]));
          chk("stall_in_done", 64'(stallreq), 64'(0));
        end
      end
    end
  end

  // Bus monitor: every ACCESS cycle must match the head entry; pop when ce drops.
  initial begin
    logic prev_ce;
    logic [68:0] b;
    prev_ce = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_ce) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", 64'(bus_ce), 64'(0));
        end else begin
          b = bus_q[0];
          chk("bus_we", 64'(bus_we), 64'(b[68]));
          chk("bus_sel", 64'(bus_sel), 64'(b[67:64]));
          chk("bus_addr", 64'(bus_addr), 64'(b[63:32]));
          chk("bus_wdata", 64'(bus_wdata), 64'(b[31:0]));
        end
      end else if (prev_ce && bus_q.size() != 0) begin
        void'(bus_q.pop_front());
      end
      prev_ce = bus_ce;
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic [31:0] rd,
                        input logic bus_exp, input logic [3:0] esel,
                        input logic [31:0] eaddr, input logic [31:0] ewdata,
                        input logic eerr, input logic [31:0] erdata,
                        input int elat, input int ece);
    int n;
    int ce_cnt;
    logic got;
    @(negedge clk);
    ack_after  = ack_at;
    rdata_cfg  = rd;
    exp_q.push_back({eerr, erdata});
    if (bus_exp) bus_q.push_back({we, esel, eaddr, ewdata});
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
    chk("stall_at_accept", 64'(stallreq), 64'(1));
    n = 0; ce_cnt = 0; got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) req_valid = 1'b0;
      if (bus_ce) ce_cnt++;
      if (resp_valid) got = 1'b1;
    end
    chk("resp_seen", 64'(got), 64'(1));
    chk("latency", 64'(n), 64'(elat));
    chk("bus_ce_cycles", 64'(ce_cnt), 64'(ece));
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("rst_bus_ce", 64'(bus_ce), 64'(0));
    chk("rst_stallreq", 64'(stallreq), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    chk("rst_resp_err", 64'(resp_err), 64'(0));
    chk("rst_bus_sel", 64'(bus_sel), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    //      we    size   sgn   addr          wdata         ack rd            bus  sel      baddr         bwdata        err   rdata         lat ce
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        0,  32'h11223344, 1'b1, 4'b1111, 32'h0000_0100, 32'h0,        1'b0, 32'h11223344, 2,  1);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        0,  32'h000000F0, 1'b1, 4'b0001, 32'h0000_0100, 32'h0,        1'b0, 32'hFFFFFFF0, 2,  1);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        0,  32'h000000F0, 1'b1, 4'b0001, 32'h0000_0100, 32'h0,        1'b0, 32'h000000F0, 2,  1);
    do_req(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000ABCD, 0,  32'hDEADBEEF, 1'b1, 4'b0011, 32'h0000_0200, 32'hABCDABCD, 1'b0, 32'h0,        2,  1);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        0,  32'h0,        1'b0, 4'b0000, 32'h0,         32'h0,        1'b1, 32'h0,        1,  0);
    do_req(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        0,  32'h0,        1'b0, 4'b0000, 32'h0,         32'h0,        1'b1, 32'h0,        1,  0);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0,        2,  32'h80011234, 1'b1, 4'b1100, 32'h0000_0100, 32'h0,        1'b0, 32'hFFFF8001, 4,  3);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,        0,  32'h12AB3456, 1'b1, 4'b0100, 32'h0000_0100, 32'h0,        1'b0, 32'h000000AB, 2,  1);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'h0,        0,  32'h0,        1'b0, 4'b0000, 32'h0,         32'h0,        1'b1, 32'h0,        1,  0);
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0302, 32'h1234565A, 0,  32'h0,        1'b1, 4'b0010, 32'h0000_0300, 32'h5A5A5A5A, 1'b0, 32'h0,        2,  1);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,        -1, 32'h55555555, 1'b1, 4'b1111, 32'h0000_0400, 32'h0,        1'b1, 32'h0,        16, 15);

    // Reset in the middle of a bus cycle: outputs must drop at once, no response follows.
    @(negedge clk);
    ack_after = -1;
    bus_q.push_back({1'b0, 4'b1111, 32'h0000_0600, 32'h0});
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0000_0600; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_bus_ce", 64'(bus_ce), 64'(0));
    chk("midrst_stallreq", 64'(stallreq), 64'(0));
    chk("midrst_resp_valid", 64'(resp_valid), 64'(0));
    chk("midrst_state", 64'(dbg_state), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0500, 32'hCAFEF00D, 1,  32'h0,        1'b1, 4'b1111, 32'h0000_0500, 32'hCAFEF00D, 1'b0, 32'h0,        3,  2);

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", 64'(exp_q.size()), 64'(0));
    chk("bus_queue_drained", 64'(bus_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
